// File: rtl/cdb_arbiter_pkg.sv
// Shared constants and helpers for the common data bus arbiter and its
// round-robin picker.
package cdb_arbiter_pkg;

  localparam int NUM_SRC = 3;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 4;
  localparam int SRC_W   = 2;

  // ROB tag 0 means "no dependency" and is never put on the bus.
  localparam logic [TAG_W-1:0] NULL_TAG = '0;

  // Producer indices on the request ports.
  typedef enum logic [SRC_W-1:0] {
    SRC_ALU = 2'd0,
    SRC_LSB = 2'd1,
    SRC_BR  = 2'd2
  } src_id_e;

  // Index of the source after idx, wrapping at NUM_SRC.
  function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] idx);
    if (int'(idx) >= NUM_SRC - 1) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Purely combinational round-robin picker: starting at ptr, the first
// requesting slot (wrapping modulo N) wins. Also used by the RS issue logic.
module cdb_rr_pick #(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     full,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] winner,
  output logic             any_grant
);

  logic [IDX_W-1:0] idx;

  // Walk the slots in priority order from ptr and keep the first full one.
  always_comb begin
    grant     = '0;
    winner    = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = IDX_W'((int'(ptr) + k) % N);
      if (!any_grant && full[idx]) begin
        any_grant   = 1'b1;
        grant[idx]  = 1'b1;
        winner      = idx;
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: each producing unit (ALU, LSB, branch) parks one
// {tag, data} result in a one-entry buffer; a round-robin picker chooses one
// buffer per cycle and its contents are broadcast on registered CDB outputs.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        req_valid,
  input  logic [NUM_SRC*TAG_W-1:0]  req_tag,
  input  logic [NUM_SRC*DATA_W-1:0] req_data,
  output logic [NUM_SRC-1:0]        req_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src
);

  logic [NUM_SRC-1:0]             full_q, full_d;
  logic [NUM_SRC-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic [NUM_SRC-1:0][DATA_W-1:0] data_q, data_d;
  logic [SRC_W-1:0]               ptr_q, ptr_d;
  logic                           cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]               cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]              cdb_data_q, cdb_data_d;
  logic [SRC_W-1:0]               cdb_src_q, cdb_src_d;

  logic [NUM_SRC-1:0] grant;
  logic [SRC_W-1:0]   winner;
  logic               any_grant;

  cdb_rr_pick #(
    .N     (NUM_SRC),
    .IDX_W (SRC_W)
  ) u_pick (
    .full      (full_q),
    .ptr       (ptr_q),
    .grant     (grant),
    .winner    (winner),
    .any_grant (any_grant)
  );

  // A buffer can take a new result when empty or when it drains this cycle;
  // nothing is taken while reset or flush is active.
  assign req_ready = {NUM_SRC{~rst & ~flush}} & (~full_q | grant);

  // Next-state: broadcast the winner, drain it, advance the pointer, then
  // capture accepted results (a refill beats the drain of the same slot).
  always_comb begin
    full_d      = full_q;
    tag_d       = tag_q;
    data_d      = data_q;
    ptr_d       = ptr_q;
    cdb_valid_d = 1'b0;
    cdb_tag_d   = cdb_tag_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    if (flush) begin
      full_d = '0;
      ptr_d  = '0;
    end else begin
      if (any_grant) begin
        cdb_valid_d    = 1'b1;
        cdb_tag_d      = tag_q[winner];
        cdb_data_d     = data_q[winner];
        cdb_src_d      = winner;
        full_d[winner] = 1'b0;
        ptr_d          = next_src(winner);
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (req_valid[i] && req_ready[i] &&
            (req_tag[i*TAG_W +: TAG_W] != NULL_TAG)) begin
          full_d[i] = 1'b1;
          tag_d[i]  = req_tag[i*TAG_W +: TAG_W];
          data_d[i] = req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // State registers; reset empties every buffer and clears the bus at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q      <= '0;
      tag_q       <= '0;
      data_q      <= '0;
      ptr_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
    end else begin
      full_q      <= full_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      ptr_q       <= ptr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_tag_q   <= cdb_tag_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: hand-built vector table, a few multi-cycle corner
// sequences, and randomized traffic checked against a behavioural model.
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [2:0]  req_valid;
  logic [11:0] req_tag;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [1:0]  cdb_src;

  int vecCount  = 0;
  int missCount = 0;

  // Behavioural model state: three one-slot buffers and the bus outputs.
  bit          mFull[3];
  logic [3:0]  mTag[3];
  logic [31:0] mData[3];
  int          mPtr;
  logic        mValid;
  logic [3:0]  mCdbTag;
  logic [31:0] mCdbData;
  logic [1:0]  mCdbSrc;

  typedef struct {
    logic [2:0] valid;
    logic [3:0] t0, t1, t2;
    logic       fl;
    logic [2:0] expReady;
    logic       expValid;
    logic [3:0] expTag;
    logic [1:0] expSrc;
  } vec_t;

  vec_t tbl[20];

  cdb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dataOf(input int src, input logic [3:0] t);
    if (t == 4'd0) return 32'h0000_DEAD;
    return 32'hD000_0000 | (32'(src) << 8) | 32'(t);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 3; i++) begin
      mFull[i] = 1'b0;
      mTag[i]  = '0;
      mData[i] = '0;
    end
    mPtr     = 0;
    mValid   = 1'b0;
    mCdbTag  = '0;
    mCdbData = '0;
    mCdbSrc  = '0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Entered at posedge+1: drive inputs, sample req_ready mid-cycle, cross the
  // edge while stepping the model, and return at posedge+1.
  task automatic applyStimulus(input logic [2:0] v, input logic [3:0] t0, t1, t2,
                               input logic [31:0] d0, d1, d2, input logic fl,
                               output logic [2:0] readySeen,
                               output logic [2:0] readyModel);
    logic [3:0]  t[3];
    logic [31:0] d[3];
    int win;
    t[0] = t0; t[1] = t1; t[2] = t2;
    d[0] = d0; d[1] = d1; d[2] = d2;
    req_valid = v;
    req_tag   = {t2, t1, t0};
    req_data  = {d2, d1, d0};
    flush     = fl;
    #2;
    readySeen = req_ready;
    win = -1;
    for (int k = 0; k < 3; k++) begin
      if (win < 0 && mFull[(mPtr + k) % 3]) win = (mPtr + k) % 3;
    end
    for (int i = 0; i < 3; i++) begin
      readyModel[i] = !fl && (!mFull[i] || win == i);
    end
    @(posedge clk);
    if (fl) begin
      for (int i = 0; i < 3; i++) mFull[i] = 1'b0;
      mPtr   = 0;
      mValid = 1'b0;
    end else begin
      if (win >= 0) begin
        mValid     = 1'b1;
        mCdbTag    = mTag[win];
        mCdbData   = mData[win];
        mCdbSrc    = 2'(win);
        mFull[win] = 1'b0;
        mPtr       = (win + 1) % 3;
      end else begin
        mValid = 1'b0;
      end
      for (int i = 0; i < 3; i++) begin
        if (v[i] && readyModel[i] && t[i] != 4'd0) begin
          mFull[i] = 1'b1;
          mTag[i]  = t[i];
          mData[i] = d[i];
        end
      end
    end
    #1;
  endtask

  task automatic doReset();
    rst       = 1'b1;
    flush     = 1'b0;
    req_valid = 3'b111;
    req_tag   = '0;
    req_data  = '0;
    @(posedge clk);
    #2;
    checkOutput("ready_in_reset", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = '0;
    modelReset();
  endtask

  initial begin
    logic [2:0] rs, rm;
    logic [3:0] rt0, rt1, rt2;
    logic [31:0] expData;

    rst = 1'b1;
    flush = 1'b0;
    req_valid = '0;
    req_tag = '0;
    req_data = '0;

    // ready, valid, tag, src expected after each vector (see sequence notes)
    tbl[0]  = '{3'b111, 4'd1, 4'd2, 4'd3, 1'b0, 3'b111, 1'b0, 4'd0, 2'd0};
    tbl[1]  = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 3'b001, 1'b1, 4'd1, 2'd0};
    tbl[2]  = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 3'b011, 1'b1, 4'd2, 2'd1};
    tbl[3]  = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 3'b111, 1'b1, 4'd3, 2'd2};
    tbl[4]  = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 3'b111, 1'b0, 4'd3, 2'd2};
    tbl[5]  = '{3'b010, 4'd0, 4'd0, 4'd0, 1'b0, 3'b111, 1'b0, 4'd3, 2'd2};
    tbl[6]  = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 3'b111, 1'b0, 4'd3, 2'd2};
    tbl[7]  = '{3'b101, 4'd4, 4'd0, 4'd8, 1'b0, 3'b111, 1'b0, 4'd3, 2'd2};
    tbl[8]  = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b1, 3'b000, 1'b0, 4'd3, 2'd2};
    tbl[9]  = '{3'b100, 4'd0, 4'd0, 4'd2, 1'b0, 3'b111, 1'b0, 4'd3, 2'd2};
    tbl[10] = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 3'b111, 1'b1, 4'd2, 2'd2};
    tbl[11] = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 3'b111, 1'b0, 4'd2, 2'd2};
    tbl[12] = '{3'b011, 4'd5, 4'd9, 4'd0, 1'b0, 3'b111, 1'b0, 4'd2, 2'd2};
    tbl[13] = '{3'b011, 4'd6, 4'd9, 4'd0, 1'b0, 3'b101, 1'b1, 4'd5, 2'd0};
    tbl[14] = '{3'b011, 4'd7, 4'd9, 4'd0, 1'b0, 3'b110, 1'b1, 4'd9, 2'd1};
    tbl[15] = '{3'b011, 4'd7, 4'd9, 4'd0, 1'b0, 3'b101, 1'b1, 4'd6, 2'd0};
    tbl[16] = '{3'b010, 4'd0, 4'd9, 4'd0, 1'b0, 3'b110, 1'b1, 4'd9, 2'd1};
    tbl[17] = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 3'b101, 1'b1, 4'd7, 2'd0};
    tbl[18] = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 3'b111, 1'b1, 4'd9, 2'd1};
    tbl[19] = '{3'b000, 4'd0, 4'd0, 4'd0, 1'b0, 3'b111, 1'b0, 4'd9, 2'd1};

    // Reset state
    doReset();
    checkOutput("rst_valid", 32'(cdb_valid), 32'd0);
    checkOutput("rst_tag",   32'(cdb_tag),   32'd0);
    checkOutput("rst_data",  cdb_data,       32'd0);
    checkOutput("rst_src",   32'(cdb_src),   32'd0);

    // Single request: ALU tag 3 / 0xAA, broadcast two edges later for one cycle
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, rs, rm);
    applyStimulus(3'b001, 4'd3, 0, 0, 32'hAA, 0, 0, 1'b0, rs, rm);
    checkOutput("single_ready", 32'(rs[0]), 32'd1);
    checkOutput("single_early", 32'(cdb_valid), 32'd0);
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, rs, rm);
    checkOutput("single_valid", 32'(cdb_valid), 32'd1);
    checkOutput("single_tag",   32'(cdb_tag),   32'd3);
    checkOutput("single_data",  cdb_data,       32'hAA);
    checkOutput("single_src",   32'(cdb_src),   32'd0);
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, rs, rm);
    checkOutput("single_once", 32'(cdb_valid), 32'd0);
    checkOutput("single_hold", 32'(cdb_tag),   32'd3);

    // Async reset while a broadcast is on the bus
    doReset();
    applyStimulus(3'b100, 0, 0, 4'd7, 0, 0, 32'h77, 1'b0, rs, rm);
    applyStimulus(3'b000, 0, 0, 0, 0, 0, 0, 1'b0, rs, rm);
    checkOutput("arst_pre_valid", 32'(cdb_valid), 32'd1);
    req_valid = 3'b111;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_valid", 32'(cdb_valid), 32'd0);
    checkOutput("arst_tag",   32'(cdb_tag),   32'd0);
    checkOutput("arst_data",  cdb_data,       32'd0);
    checkOutput("arst_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("arst_ready_hold", 32'(req_ready), 32'd0);
    rst = 1'b0;
    req_valid = '0;
    modelReset();
    #1;
    checkOutput("arst_ready_release", 32'(req_ready), 32'd7);

    // Table: contention, reserved tag, flush, back-to-back refill
    doReset();
    for (int n = 0; n < 20; n++) begin
      applyStimulus(tbl[n].valid, tbl[n].t0, tbl[n].t1, tbl[n].t2,
                    dataOf(0, tbl[n].t0), dataOf(1, tbl[n].t1), dataOf(2, tbl[n].t2),
                    tbl[n].fl, rs, rm);
      expData = (tbl[n].expTag == 4'd0) ? 32'd0 : dataOf(int'(tbl[n].expSrc), tbl[n].expTag);
      checkOutput($sformatf("vec%0d_ready", n), 32'(rs),        32'(tbl[n].expReady));
      checkOutput($sformatf("vec%0d_valid", n), 32'(cdb_valid), 32'(tbl[n].expValid));
      checkOutput($sformatf("vec%0d_tag", n),   32'(cdb_tag),   32'(tbl[n].expTag));
      checkOutput($sformatf("vec%0d_src", n),   32'(cdb_src),   32'(tbl[n].expSrc));
      checkOutput($sformatf("vec%0d_data", n),  cdb_data,       expData);
    end

    // Random traffic against the model
    doReset();
    for (int n = 0; n < 400; n++) begin
      rt0 = 4'($urandom_range(0, 15));
      rt1 = 4'($urandom_range(0, 15));
      rt2 = 4'($urandom_range(0, 15));
      applyStimulus(3'($urandom_range(0, 7)), rt0, rt1, rt2,
                    $urandom, $urandom, $urandom,
                    ($urandom_range(0, 19) == 0), rs, rm);
      checkOutput("rnd_ready", 32'(rs),        32'(rm));
      checkOutput("rnd_valid", 32'(cdb_valid), 32'(mValid));
      checkOutput("rnd_tag",   32'(cdb_tag),   32'(mCdbTag));
      checkOutput("rnd_src",   32'(cdb_src),   32'(mCdbSrc));
      checkOutput("rnd_data",  cdb_data,       mCdbData);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
